output_acc_drain_buffer: RTL and testbench

Parametrised column buffer at the bottom of one systolic-array column. It collects DEPTH partial sums per tile through a shift register and accumulates them across K tiles in a wider accumulator bank. It then drains the results one word per handshake to the output buffer. Multiple columns are formed by instantiating this block once per column under a shared controller.

---
 rtl/output_acc_drain_buffer_if.sv | 31 +++
 rtl/output_acc_drain_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_output_acc_drain_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_acc_drain_buffer_if.sv
// rtl/output_acc_drain_buffer_if.sv - tile input and drain output streams of one column buffer
// Ports (interface signals):
//   in_valid/in_ready/in_data     partial-sum input stream
//   tile_first/tile_last          tile flags, meaningful on the first beat of a tile
//   out_valid/out_ready/out_data  accumulator drain stream
//   out_last                      final word of a drain
// Modports: master drives the input stream and out_ready, slave is the buffer.
interface output_acc_drain_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              tile_first;
  logic              tile_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, tile_first, tile_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, tile_first, tile_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/output_acc_drain_buffer.sv
// rtl/output_acc_drain_buffer.sv - column tile collector, K-tile accumulator and word drain
// Optional feature macro: OUTPUT_ACC_SAT_EN (saturating accumulate, sticky sat_flag_o)
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   flush_i     synchronous abort, same end state as reset
//   bus         slave side of output_acc_drain_buffer_if (input tile stream, drain stream)
//   busy_o      high whenever the block is not IDLE
//   sat_flag_o  sticky saturation indicator, tied 0 when the feature is compiled out
module output_acc_drain_buffer #(
  parameter int  DATA_W = 16,
  parameter int  ACC_W  = 32,
  parameter int  DEPTH  = 16,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  output_acc_drain_buffer_if.slave bus,
  output logic                    busy_o,
  output logic                    sat_flag_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ACC   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] slot_q [DEPTH];
  logic [ACC_W-1:0]  acc_q  [DEPTH];

  logic [ACC_W-1:0]  lane_base [DEPTH];
  logic [ACC_W-1:0]  lane_ext  [DEPTH];
  logic [ACC_W-1:0]  acc_sum   [DEPTH];
  logic [ACC_W-1:0]  rd_word;

  logic in_ready;
  logic out_valid;
  logic beat;
  logic out_hs;
  logic acc_upd;
  logic acc_clr;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign out_valid = (state_q == S_DRAIN);
  assign beat = bus.in_valid && in_ready;
  assign out_hs = out_valid && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? rd_word : '0;
  assign bus.out_last  = out_valid && (rd_ptr_q == CNT_W'(DEPTH - 1));
  assign busy_o        = (state_q != S_IDLE);

  // Control: tile flags are captured only on the first beat of a tile.
  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    rd_ptr_d = rd_ptr_q;
    first_d  = first_q;
    last_d   = last_q;
    acc_upd  = 1'b0;
    acc_clr  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (beat) begin
          first_d  = bus.tile_first;
          last_d   = bus.tile_last;
          ld_cnt_d = CNT_W'(1);
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (beat) begin
          if (ld_cnt_q == CNT_W'(DEPTH - 1)) begin
            ld_cnt_d = '0;
            state_d  = S_ACC;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      end
      S_ACC: begin
        acc_upd = 1'b1;
        state_d = last_q ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (out_hs) begin
          if (rd_ptr_q == CNT_W'(DEPTH - 1)) begin
            rd_ptr_d = '0;
            acc_clr  = 1'b1;
            state_d  = S_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-lane addends: a first tile overwrites, so its base is zero.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      lane_base[i] = first_q ? '0 : acc_q[i];
      lane_ext[i]  = ACC_W'($signed(slot_q[i]));
    end
  end

`ifdef OUTPUT_ACC_SAT_EN
  logic [ACC_W:0] lane_wide [DEPTH];
  logic           clamp_any;
  logic           sat_q;

  // One guard bit: overflow when the two top bits of the widened sum differ.
  always_comb begin
    clamp_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      lane_wide[i] = {lane_base[i][ACC_W-1], lane_base[i]} + {lane_ext[i][ACC_W-1], lane_ext[i]};
      if (lane_wide[i][ACC_W] != lane_wide[i][ACC_W-1]) begin
        clamp_any  = 1'b1;
        acc_sum[i] = lane_wide[i][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_sum[i] = lane_wide[i][ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (flush_i) begin
      sat_q <= 1'b0;
    end else if (acc_upd && clamp_any) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_flag_o = sat_q;
`else
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      acc_sum[i] = lane_base[i] + lane_ext[i];
    end
  end

  assign sat_flag_o = 1'b0;
`endif

  // Read mux written as a compare loop so the counter width never has to match the array index width.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_ptr_q == CNT_W'(i)) begin
        rd_word = acc_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ld_cnt_q <= '0;
      rd_ptr_q <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else if (flush_i) begin
      state_q  <= S_IDLE;
      ld_cnt_q <= '0;
      rd_ptr_q <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      first_q  <= first_d;
      last_q   <= last_d;
      // Shift toward slot 0 so that after DEPTH beats beat k sits in slot k.
      if (beat) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          slot_q[i] <= slot_q[i+1];
        end
        slot_q[DEPTH-1] <= bus.in_data;
      end
      if (acc_upd) begin
        for (int i = 0; i < DEPTH; i++) begin
          acc_q[i] <= acc_sum[i];
        end
      end else if (acc_clr) begin
        for (int i = 0; i < DEPTH; i++) begin
          acc_q[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_output_acc_drain_buffer.sv
// tb/tb_output_acc_drain_buffer.sv - randomized self-checking bench for output_acc_drain_buffer
module tb_output_acc_drain_buffer;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int DEPTH  = 4;
  localparam int SAT_W  = 16;

  typedef logic [ACC_W:0] word_t;

  logic clk = 1'b0;
  logic rst;
  logic flush, flush2;
  logic busy, sat, busy2, sat2;

  always #5 clk = ~clk;

  output_acc_drain_buffer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();
  output_acc_drain_buffer_if #(.DATA_W(DATA_W), .ACC_W(SAT_W)) bus2 ();

  output_acc_drain_buffer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush), .bus(bus), .busy_o(busy), .sat_flag_o(sat)
  );

  output_acc_drain_buffer #(.DATA_W(DATA_W), .ACC_W(SAT_W), .DEPTH(DEPTH)) u_dut_sat (
    .clk(clk), .rst(rst), .flush_i(flush2), .bus(bus2), .busy_o(busy2), .sat_flag_o(sat2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: signed accumulator values per lane, expected drain words in order.
  longint macc   [DEPTH];
  longint tile_d [DEPTH];
  word_t  exp_q  [$];
  int     hs_cnt = 0;
  int     rdy_mode = 0;
  bit     rdy_pat [$];

  function automatic longint wrap_to(input longint v, input int w);
    longint m;
    longint r;
    m = longint'(1) << w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) macc[i] = 0;
    exp_q.delete();
  endfunction

  function automatic void model_tile(input bit first, input bit last);
    word_t w;
    for (int i = 0; i < DEPTH; i++) begin
      macc[i] = wrap_to((first ? 0 : macc[i]) + tile_d[i], ACC_W);
    end
    if (last) begin
      for (int i = 0; i < DEPTH; i++) begin
        w[ACC_W-1:0] = macc[i][ACC_W-1:0];
        w[ACC_W]     = (i == DEPTH - 1);
        exp_q.push_back(w);
        macc[i] = 0;
      end
    end
  endfunction

  task automatic send_tile(input int nbeats, input bit first, input bit last, input bit gaps, input bit keep);
    for (int k = 0; k < nbeats; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          bus.in_data  = DATA_W'($urandom);
          @(posedge clk); #1;
        end
      end
      bus.in_valid   = 1'b1;
      bus.in_data    = tile_d[k][DATA_W-1:0];
      bus.tile_first = (k == 0) ? first : 1'($urandom_range(0, 1));
      bus.tile_last  = (k == 0) ? last  : 1'($urandom_range(0, 1));
      begin
        bit ok = 1'b0;
        int g  = 0;
        while (!ok && g < 200) begin
          @(negedge clk);
          ok = bus.in_ready;
          @(posedge clk); #1;
          g++;
        end
        if (!ok) check("in_ready_timeout", 0, 1);
      end
    end
    if (keep) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0BAD;
    end else begin
      bus.in_valid = 1'b0;
    end
    if (nbeats == DEPTH) model_tile(first, last);
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain_done", 64'((exp_q.size() == 0) && !busy), 1);
  endtask

  task automatic set_tile(input longint a, input longint b, input longint c, input longint d);
    tile_d[0] = a; tile_d[1] = b; tile_d[2] = c; tile_d[3] = d;
  endtask

  initial begin : ready_gen
    forever begin
      @(posedge clk); #2;
      if (rdy_pat.size() != 0) bus.out_ready = rdy_pat.pop_front();
      else if (rdy_mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
      else bus.out_ready = 1'b1;
    end
  end

  // Every drain handshake is checked against the model; stalled words must hold.
  initial begin : monitor
    word_t held;
    word_t obs;
    bit    hold_pend;
    hold_pend = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      obs = {bus.out_last, bus.out_data};
      if (rst || flush) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("hold_valid", 64'(bus.out_valid), 1);
          check("hold_word", 64'(obs), 64'(held));
        end
        if (!bus.out_valid) check("idle_out_zero", 64'(obs), 0);
        if (bus.out_valid && bus.out_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) check("unexpected_word", 64'(obs), 64'hDEAD);
          else check("drain_word", 64'(obs), 64'(exp_q.pop_front()));
        end
        hold_pend = bus.out_valid && !bus.out_ready;
        held = obs;
      end
    end
  end

  initial begin : main
    logic signed [DATA_W-1:0] r;
    logic [SAT_W-1:0] got [4];
    logic [SAT_W-1:0] exp16;
    bit exp_sat;
    int got_n;
    int n;
    bit acc_ok;
    int hs0;

    rst = 1'b1; flush = 1'b0; flush2 = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.tile_first = 1'b0; bus.tile_last = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.tile_first = 1'b0; bus2.tile_last = 1'b0;
    bus2.out_ready = 1'b1;
    model_clear();
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 1);
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_out_data", 64'(bus.out_data), 0);
    check("rst_out_last", 64'(bus.out_last), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_sat", 64'(sat), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single tile: valid appears two cycles after the last beat's cycle, then DEPTH words.
    set_tile(1, 2, 3, 4);
    send_tile(DEPTH, 1, 1, 0, 0);
    check("s1_acc_no_valid", 64'(bus.out_valid), 0);
    check("s1_acc_in_ready", 64'(bus.in_ready), 0);
    @(posedge clk); #1;
    check("s1_valid_rise", 64'(bus.out_valid), 1);
    check("s1_first_word", 64'(bus.out_data), 1);
    repeat (DEPTH) @(posedge clk);
    #1;
    check("s1_busy_after", 64'(busy), 0);
    check("s1_all_drained", 64'(exp_q.size()), 0);

    // Three tiles accumulated.
    set_tile(10, -20, 30, -40);
    send_tile(DEPTH, 1, 0, 0, 0);
    send_tile(DEPTH, 0, 0, 0, 0);
    send_tile(DEPTH, 0, 1, 0, 0);
    wait_drain();

    // Backpressure pattern during drain.
    set_tile(7, -8, 9, 10);
    send_tile(DEPTH, 1, 1, 0, 0);
    @(posedge clk); #1;
    hs0 = hs_cnt;
    foreach (rdy_pat[i]) rdy_pat.delete(i);
    rdy_pat.push_back(1); rdy_pat.push_back(0); rdy_pat.push_back(0); rdy_pat.push_back(1);
    rdy_pat.push_back(1); rdy_pat.push_back(0); rdy_pat.push_back(1);
    wait_drain();
    check("s3_handshakes", 64'(hs_cnt - hs0), 4);

    // in_valid held through ACC and DRAIN is not consumed.
    set_tile(11, 12, 13, 14);
    send_tile(DEPTH, 1, 1, 0, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("s4_in_ready_low", 64'(bus.in_ready), 0);
      if (c < 4) begin
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("s4_idle", 64'(busy), 0);
    set_tile(21, -22, 23, 24);
    send_tile(DEPTH, 1, 1, 0, 0);
    wait_drain();

    // Flush mid-LOAD.
    set_tile(100, 200, 300, 400);
    send_tile(2, 1, 1, 0, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
    check("s5_busy_after_flush", 64'(busy), 0);
    check("s5_in_ready_after_flush", 64'(bus.in_ready), 1);
    set_tile(5, 6, 7, 8);
    send_tile(DEPTH, 1, 1, 0, 0);
    wait_drain();

    // Flush mid-DRAIN, then a non-first tile must land on zeros.
    rdy_mode = 1;
    set_tile(1000, 2000, 3000, 4000);
    send_tile(DEPTH, 1, 1, 0, 0);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    model_clear();
    @(posedge clk); #1;
    flush = 1'b0;
    check("s5_drain_flush_busy", 64'(busy), 0);
    check("s5_drain_flush_valid", 64'(bus.out_valid), 0);
    set_tile(9, 9, -9, 9);
    send_tile(DEPTH, 0, 1, 1, 0);
    wait_drain();

    // Asynchronous reset mid-LOAD.
    set_tile(3, 3, 3, 3);
    send_tile(2, 1, 1, 0, 0);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy), 0);
    check("rst_mid_in_ready", 64'(bus.in_ready), 1);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;

    // Random tiles, random gaps and random backpressure.
    for (int t = 0; t < 40; t++) begin
      bit f, l;
      for (int k = 0; k < DEPTH; k++) begin
        r = DATA_W'($urandom);
        tile_d[k] = r;
      end
      f = ($urandom_range(0, 2) == 0);
      l = ($urandom_range(0, 2) == 0) || (t == 39);
      send_tile(DEPTH, f, l, 1, 0);
    end
    wait_drain();
    check("rand_sat_flag", 64'(sat), 0);
    rdy_mode = 0;

    // Two tiles of 0x7FFF on a 16-bit accumulator.
`ifdef OUTPUT_ACC_SAT_EN
    exp16 = 16'h7FFF;
    exp_sat = 1'b1;
`else
    exp16 = 16'hFFFE;
    exp_sat = 1'b0;
`endif
    got_n = 0;
    n = 0;
    bus2.in_data = 16'h7FFF;
    for (int c = 0; c < 60 && got_n < 4; c++) begin
      bus2.tile_first = (n == 0);
      bus2.tile_last  = (n >= DEPTH);
      bus2.in_valid   = (n < 2 * DEPTH);
      @(negedge clk);
      acc_ok = bus2.in_valid && bus2.in_ready;
      if (bus2.out_valid && bus2.out_ready) begin
        got[got_n] = bus2.out_data;
        got_n++;
      end
      @(posedge clk); #1;
      if (acc_ok) n++;
    end
    bus2.in_valid = 1'b0;
    check("s6_word_count", 64'(got_n), 4);
    for (int i = 0; i < got_n; i++) check("s6_word", 64'(got[i]), 64'(exp16));
    check("s6_sat_flag", 64'(sat2), 64'(exp_sat));
    flush2 = 1'b1;
    @(posedge clk); #1;
    flush2 = 1'b0;
    check("s6_sat_flush", 64'(sat2), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
